// File: rtl/dr_pkg.sv
// Shared constants, FSM state type and sizing helper for the dual-rail receiver.
package dr_pkg;

  localparam logic [15:0] ENC_TP = "TP";
  localparam logic [15:0] ENC_FP = "FP";

  localparam logic T_RAIL = 1'b1;
  localparam logic F_RAIL = 1'b0;

  typedef enum logic {
    WAIT_TOKEN = 1'b0,
    WAIT_NULL  = 1'b1
  } fsm_state_e;

  function automatic int clog2_cnt(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dr_rx_decode.sv
// Rail synchronisers plus completion, data and protocol-error decode for both encodings.
module dr_rx_decode
  import dr_pkg::*;
#(
  parameter logic [15:0] ENC         = ENC_TP,
  parameter int          WIDTH       = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0][1:0]  i_rails,
  input  logic                   i_capture,
  output logic                   o_tok_cmpl,
  output logic                   o_tok_null,
  output logic [WIDTH-1:0]       o_tok_data,
  output logic                   o_proto_err
);

  localparam logic IS_TP = (ENC == ENC_TP);

  logic [SYNC_STAGES-1:0][WIDTH-1:0][1:0] r_sync;
  logic                                   r_ph;
  logic [WIDTH-1:0]                       r_prev_r1;
  logic [WIDTH-1:0]                       r_prev_r0;

  logic [WIDTH-1:0][1:0] w_s;
  logic [WIDTH-1:0]      w_t;
  logic [WIDTH-1:0]      w_f;

  // NOTE: every clocked register uses non-blocking assignment so all flops sample the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rails};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_t[i] = w_s[i][T_RAIL];
    assign w_f[i] = w_s[i][F_RAIL];
  end

  // Two-phase state: the parity expected for "no new token" and the rails seen at the last capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ph      <= 1'b0;
      r_prev_r1 <= '0;
      r_prev_r0 <= '0;
    end else if (i_capture) begin
      r_ph      <= ~r_ph;
      r_prev_r1 <= w_t;
      r_prev_r0 <= w_f;
    end
  end

  logic             w_tp_cmpl;
  logic             w_tp_err;
  logic [WIDTH-1:0] w_tp_data;
  logic             w_fp_cmpl;
  logic             w_fp_err;

  assign w_tp_cmpl = &((w_t ^ w_f) ^ {WIDTH{r_ph}});
  assign w_tp_data = w_t ^ r_prev_r1;
  assign w_tp_err  = |((w_t ^ r_prev_r1) & (w_f ^ r_prev_r0));

  // A bit showing 11 is neither a valid value nor a spacer, so it blocks completion.
  assign w_fp_cmpl = &(w_t ^ w_f);
  assign w_fp_err  = |(w_t & w_f);

  assign o_tok_cmpl  = IS_TP ? w_tp_cmpl : w_fp_cmpl;
  assign o_tok_data  = IS_TP ? w_tp_data : w_t;
  assign o_proto_err = IS_TP ? w_tp_err  : w_fp_err;
  assign o_tok_null  = ~|(w_t | w_f);

endmodule

// File: rtl/dr_sync_rx_fifo.sv
// Dual-rail channel receiver feeding a DEPTH-entry clocked FIFO; back-pressure withholds ack.
module dr_sync_rx_fifo
  import dr_pkg::*;
#(
  parameter logic [15:0] ENC         = ENC_TP,
  parameter int          WIDTH       = 8,
  parameter int          DEPTH       = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0][1:0]         in,
  output logic                          ack_o,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [clog2_cnt(DEPTH)-1:0]   count,
  output logic                          err
);

  localparam int   CW    = clog2_cnt(DEPTH);
  localparam int   PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic IS_TP = (ENC == ENC_TP);

  logic             w_tok_cmpl;
  logic             w_tok_null;
  logic [WIDTH-1:0] w_tok_data;
  logic             w_proto_err;
  logic             w_push;
  logic             w_pop;

  fsm_state_e       r_state;
  logic             r_ack;
  logic             r_err;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_last;

  dr_rx_decode #(
    .ENC         (ENC),
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_decode (
    .clk         (clk),
    .rst         (rst),
    .i_rails     (in),
    .i_capture   (w_push),
    .o_tok_cmpl  (w_tok_cmpl),
    .o_tok_null  (w_tok_null),
    .o_tok_data  (w_tok_data),
    .o_proto_err (w_proto_err)
  );

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Fullness uses the registered count, so a full FIFO popping this cycle accepts the token next cycle.
  assign w_push    = (r_state == WAIT_TOKEN) && w_tok_cmpl && (r_count < CW'(DEPTH));
  assign w_pop     = out_valid && out_ready;
  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : r_last;
  assign count     = r_count;
  assign ack_o     = r_ack;
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= WAIT_TOKEN;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_proto_err) r_err <= 1'b1;
      case (r_state)
        WAIT_TOKEN: begin
          if (w_push) begin
            if (IS_TP) begin
              r_ack <= ~r_ack;
            end else begin
              r_ack   <= 1'b1;
              r_state <= WAIT_NULL;
            end
          end
        end
        WAIT_NULL: begin
          if (w_tok_null) begin
            r_ack   <= 1'b0;
            r_state <= WAIT_TOKEN;
          end
        end
        default: r_state <= WAIT_TOKEN;
      endcase
    end
  end

  // NOTE: the storage array has no reset; pointers and count define validity, and out_data shows r_last while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_tok_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dr_sync_rx_fifo.sv
// Bench for dr_sync_rx_fifo: a two-phase DEPTH=3 instance and a four-phase DEPTH=4 instance.
module tb_dr_sync_rx_fifo;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic              tp_rst, tp_ack, tp_valid, tp_ready, tp_err;
  logic [W-1:0][1:0] tp_in;
  logic [W-1:0]      tp_data;
  logic [1:0]        tp_count;

  logic              fp_rst, fp_ack, fp_valid, fp_ready, fp_err;
  logic [W-1:0][1:0] fp_in;
  logic [W-1:0]      fp_data;
  logic [2:0]        fp_count;

  logic [W-1:0] q[$];

  dr_sync_rx_fifo #(.ENC("TP"), .WIDTH(W), .DEPTH(3), .SYNC_STAGES(2)) u_tp (
    .clk(clk), .rst(tp_rst), .in(tp_in), .ack_o(tp_ack), .out_data(tp_data),
    .out_valid(tp_valid), .out_ready(tp_ready), .count(tp_count), .err(tp_err)
  );

  dr_sync_rx_fifo #(.ENC("FP"), .WIDTH(W), .DEPTH(4), .SYNC_STAGES(2)) u_fp (
    .clk(clk), .rst(fp_rst), .in(fp_in), .ack_o(fp_ack), .out_data(fp_data),
    .out_valid(fp_valid), .out_ready(fp_ready), .count(fp_count), .err(fp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Two-phase sender: a 1 toggles the true rail, a 0 toggles the false rail.
  task automatic tp_send(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) begin
      if (v[i]) tp_in[i][1] = ~tp_in[i][1];
      else      tp_in[i][0] = ~tp_in[i][0];
    end
  endtask

  function automatic logic [W-1:0][1:0] fp_word(input logic [W-1:0] v);
    logic [W-1:0][1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic wait_fp_ack(input logic lvl, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (fp_ack === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic fp_handshake(input logic [W-1:0] v, input string tag);
    logic ok;
    fp_in = fp_word(v);
    wait_fp_ack(1'b1, ok);
    check({tag, "_ack_hi"}, ok, 1);
    fp_in = '0;
    wait_fp_ack(1'b0, ok);
    check({tag, "_ack_lo"}, ok, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] v;
    logic         ok;
    int           got;
    logic         saw_ack;

    tp_rst = 1'b0; fp_rst = 1'b0;
    tp_in = '0; fp_in = '0;
    tp_ready = 1'b0; fp_ready = 1'b0;
    tick(2);

    check("tp_rst_ack",   tp_ack,   0);
    check("tp_rst_valid", tp_valid, 0);
    check("tp_rst_count", tp_count, 0);
    check("tp_rst_err",   tp_err,   0);
    check("tp_rst_data",  tp_data,  0);
    check("fp_rst_ack",   fp_ack,   0);
    check("fp_rst_valid", fp_valid, 0);
    check("fp_rst_count", fp_count, 0);
    check("fp_rst_err",   fp_err,   0);
    check("fp_rst_data",  fp_data,  0);

    tp_rst = 1'b1; fp_rst = 1'b1;
    tick(2);

    // Two-phase tokens with the consumer always ready; push lands SYNC_STAGES+1 edges after the rails.
    tp_ready = 1'b1;
    tp_send(8'hA5);
    tick(2);
    check("tp_a5_early", tp_valid, 0);
    tick(1);
    check("tp_a5_valid", tp_valid, 1);
    check("tp_a5_data",  tp_data,  8'hA5);
    check("tp_a5_ack",   tp_ack,   1);
    tick(1);
    check("tp_a5_popped", tp_valid, 0);
    tp_send(8'h3C);
    tick(2);
    check("tp_3c_early", tp_valid, 0);
    tick(1);
    check("tp_3c_valid", tp_valid, 1);
    check("tp_3c_data",  tp_data,  8'h3C);
    check("tp_3c_ack",   tp_ack,   0);
    tick(1);
    check("tp_3c_popped", tp_valid, 0);
    check("tp_hold_data", tp_data,  8'h3C);
    tp_ready = 1'b0;

    // Skewed 0xFF: true rails toggle a few bits per cycle over five cycles.
    for (int c = 0; c < 5; c++) begin
      check("skew_wait", tp_count, 0);
      for (int i = 0; i < W; i++) begin
        if (((i < 6) ? i / 2 : i - 3) == c) tp_in[i][1] = ~tp_in[i][1];
      end
      @(negedge clk);
    end
    tick(1);
    check("skew_pre", tp_count, 0);
    tick(1);
    check("skew_push", tp_count, 1);
    check("skew_data", tp_data,  8'hFF);
    tick(3);
    check("skew_once", tp_count, 1);
    check("skew_err",  tp_err,   0);
    tp_ready = 1'b1;
    tick(1);
    check("skew_drain", tp_valid, 0);
    tp_ready = 1'b0;

    // Wrap on DEPTH=3: hold two entries, then push and pop on the same edge for ten random tokens.
    for (int k = 0; k < 2; k++) begin
      v = W'($urandom);
      tp_send(v);
      q.push_back(v);
      tick(3);
      check("wrap_fill", tp_count, k + 1);
    end
    for (int t = 0; t < 10; t++) begin
      v = W'($urandom);
      tp_send(v);
      q.push_back(v);
      tick(2);
      tp_ready = 1'b1;
      check("wrap_head", tp_data, q[0]);
      void'(q.pop_front());
      tick(1);
      tp_ready = 1'b0;
      check("wrap_cnt", tp_count, 2);
    end
    tp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("wrap_tail", tp_data, q[0]);
      void'(q.pop_front());
      tick(1);
    end
    check("wrap_empty", tp_valid, 0);
    tp_ready = 1'b0;

    // Four-phase back-pressure: four tokens fill the FIFO, the fifth is stalled without ack.
    for (int k = 1; k <= 4; k++) fp_handshake(W'(k), "fp_bp");
    check("fp_full_cnt", fp_count, 4);
    fp_in = fp_word(8'h05);
    tick(10);
    check("fp_full_noack", fp_ack,   0);
    check("fp_full_hold",  fp_count, 4);
    fp_ready = 1'b1;
    got = 0;
    saw_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (fp_valid && got < 5) begin
        check("fp_order", fp_data, got + 1);
        got++;
      end
      if (fp_ack === 1'b1 && !saw_ack) begin
        saw_ack = 1'b1;
        fp_in = '0;
      end
      if (got == 5 && saw_ack) break;
      @(negedge clk);
    end
    check("fp_drain_n", got,     5);
    check("fp_ack5",    saw_ack, 1);
    wait_fp_ack(1'b0, ok);
    check("fp_ack5_lo", ok, 1);
    tick(2);
    check("fp_drained", fp_count, 0);
    check("fp_hold",    fp_data,  8'h05);
    fp_ready = 1'b0;

    // Illegal 11 on bit 3: error is sticky, nothing is pushed or acknowledged.
    fp_in = fp_word(8'h00);
    fp_in[3] = 2'b11;
    tick(6);
    check("ill_err",  fp_err,   1);
    check("ill_cnt",  fp_count, 0);
    check("ill_ack",  fp_ack,   0);
    fp_in = '0;
    tick(5);
    check("ill_sticky", fp_err, 1);
    fp_handshake(8'h5A, "ill_after");
    check("ill_after_cnt", fp_count, 1);
    check("ill_err_kept",  fp_err,   1);

    // Reset while in WAIT_NULL with two entries held.
    fp_in = fp_word(8'h22);
    wait_fp_ack(1'b1, ok);
    check("mid_ack_hi", ok, 1);
    check("mid_cnt",    fp_count, 2);
    #2 fp_rst = 1'b0;
    #1;
    check("mid_rst_ack",   fp_ack,   0);
    check("mid_rst_valid", fp_valid, 0);
    check("mid_rst_cnt",   fp_count, 0);
    check("mid_rst_err",   fp_err,   0);
    fp_in = '0;
    @(negedge clk);
    fp_rst = 1'b1;
    tick(1);
    fp_handshake(8'h7E, "post_rst");
    check("post_rst_valid", fp_valid, 1);
    check("post_rst_data",  fp_data,  8'h7E);
    check("post_rst_cnt",   fp_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
